// File: rtl/fir_tap_sequencer.sv
// -----------------------------------------------------------------------------
// fir_tap_sequencer
//
// Control sequencer for a lane-parallel FIR filter. For every accepted input
// sample it writes the sample buffer, steps all MAC lanes through the TPL
// taps they own, waits for the adder tree to settle, strobes the output
// register load and then offers the result to the serializer until it is
// taken.
//
// Parameters
//   FIR_DEPTH      taps / sample-buffer depth (power of two)
//   NUM_PIPELINES  parallel MAC lanes (divides FIR_DEPTH)
//   MAC_LATENCY    cycles from last acc_en to a valid adder-tree sum (>= 1)
//
// Ports
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_en            global enable; low freezes all sequencing
//   i_din_valid     new sample offered (taken when o_ready is high)
//   o_ready         sequencer idle and able to accept a sample
//   o_wr_en         sample-buffer write strobe, address o_wr_addr
//   o_samp_addr     lane-0 sample read address (lane k offsets by k*TPL)
//   o_coef_addr     coefficient address shared by all lanes
//   o_acc_clr       accumulators load the product instead of accumulating
//   o_acc_en        accumulators update
//   o_load          capture adder-tree sum into the output register
//   o_dout_valid    output register holds a word for the serializer
//   i_ready         serializer accepts the output word
//   o_primed        FIR_DEPTH samples written since reset
// -----------------------------------------------------------------------------
module fir_tap_sequencer #(
  parameter  int FIR_DEPTH     = 256,
  parameter  int NUM_PIPELINES = 8,
  parameter  int MAC_LATENCY   = 3,
  localparam int TPL           = FIR_DEPTH / NUM_PIPELINES,
  localparam int AW            = $clog2(FIR_DEPTH),
  localparam int CW            = (TPL > 1) ? $clog2(TPL) : 1,
  localparam int DW            = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_din_valid,
  output logic          o_ready,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [AW-1:0] o_samp_addr,
  output logic [CW-1:0] o_coef_addr,
  output logic          o_acc_clr,
  output logic          o_acc_en,
  output logic          o_load,
  output logic          o_dout_valid,
  input  logic          i_ready,
  output logic          o_primed
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [CW-1:0] STEP_LAST  = CW'(TPL - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LATENCY - 1);
  localparam logic [AW:0]   FILL_MAX   = (AW + 1)'(FIR_DEPTH);

  logic [2:0]    state;
  logic [AW-1:0] wr_ptr;     // newest sample slot; advances on output handshake
  logic [CW-1:0] step;       // tap index within a lane during MAC
  logic [DW-1:0] drain_cnt;  // cycles spent waiting on the MAC/adder pipeline
  logic [AW:0]   fill;       // one bit wider so FIR_DEPTH itself is representable

  assign o_primed = (fill == FILL_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others; blocking here would create
  // order-dependent simulation and mismatch synthesis.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      step      <= '0;
      drain_cnt <= '0;
      fill      <= '0;
    end else if (i_en) begin
      case (state)
        S_IDLE: begin
          if (i_din_valid) state <= S_WRITE;
        end
        S_WRITE: begin
          if (!o_primed) fill <= fill + (AW + 1)'(1);
          step  <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          if (step == STEP_LAST) begin
            step      <= '0;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            step <= step + CW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            state     <= S_OUT;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_OUT: begin
          // The next sample lands in the following slot; wraps modulo depth.
          if (i_ready) begin
            wr_ptr <= wr_ptr + AW'(1);
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are gated by i_en so a frozen sequencer never repeats an action;
  // o_dout_valid is a level and stays asserted while frozen in OUT.
  assign o_ready      = i_en && !i_rst && (state == S_IDLE);
  assign o_wr_en      = i_en && (state == S_WRITE);
  assign o_acc_en     = i_en && (state == S_MAC);
  assign o_acc_clr    = i_en && (state == S_MAC) && (step == '0);
  assign o_load       = i_en && (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);
  assign o_dout_valid = (state == S_OUT);

  assign o_wr_addr    = wr_ptr;
  assign o_coef_addr  = step;
  // Walk backwards through history from the newest sample.
  assign o_samp_addr  = wr_ptr - AW'(step);

endmodule
